// File: rtl/sat_fsm_lut_tmr.sv
// sat_fsm_lut_tmr: satellite-mode FSM whose next-state and output functions
// live in a runtime-loadable lookup table. The table is loaded serially into
// a shadow buffer and committed in one edge. State is held in three copies
// with bitwise majority voting. The voted value is written back every cycle,
// so a single upset is scrubbed on the next edge. Copy disagreements are
// flagged and counted for the health monitor.
module sat_fsm_lut_tmr #(
    parameter int N_IN  = 5,
    parameter int N_ST  = 2,
    parameter int N_OUT = 2,
    parameter int CNT_W = 8,
    localparam int A_W   = N_ST + N_IN,
    localparam int DEPTH = 2 ** A_W,
    localparam int N_FN  = N_ST + N_OUT,
    localparam int CFG_W = N_FN * DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             cfg_sdi,
    input  logic             cfg_shift,
    input  logic             cfg_commit,
    input  logic             inj_en,
    input  logic [1:0]       inj_sel,
    input  logic [N_ST-1:0]  inj_mask,
    output logic [N_ST-1:0]  state,
    output logic [N_OUT-1:0] out_vec,
    output logic             cfg_full,
    output logic             fault_flag,
    output logic [CNT_W-1:0] fault_cnt
);

    // Shift counter must be able to hold the value CFG_W itself.
    localparam int CNT_BITS = $clog2(CFG_W + 1);
    localparam logic [CNT_BITS-1:0] SHIFT_FULL = CNT_BITS'(CFG_W);

    // Loader progress: empty after reset/commit, filling while bits arrive,
    // ready once a complete table sits in the shadow buffer.
    typedef enum logic [1:0] {
        CFG_EMPTY   = 2'd0,
        CFG_FILLING = 2'd1,
        CFG_READY   = 2'd2
    } cfg_state_t;

    cfg_state_t cfg_st, cfg_nx;

    logic [CFG_W-1:0]            shadow;
    // Active table viewed as one DEPTH-bit truth table per function:
    // entries 0..N_ST-1 are next-state bits, the rest are output bits.
    logic [N_FN-1:0][DEPTH-1:0]  active;
    logic [CNT_BITS-1:0]         shift_cnt;
    logic [CNT_BITS-1:0]         shift_cnt_nx;

    logic [N_ST-1:0]  s0, s1, s2;
    logic [N_ST-1:0]  n0, n1, n2;
    logic [A_W-1:0]   addr;
    logic [N_FN-1:0]  lut_bits;
    logic [N_ST-1:0]  lut_ns;
    logic [N_OUT-1:0] lut_out;
    logic             commit_go;
    logic             mismatch;
    logic             inj0, inj1, inj2;

    // Bitwise 2-of-3 majority.
    function automatic logic [N_ST-1:0] vote3(
        input logic [N_ST-1:0] a,
        input logic [N_ST-1:0] b,
        input logic [N_ST-1:0] c
    );
        return (a & b) | (b & c) | (a & c);
    endfunction

    // Saturating increment of the fault counter.
    function automatic logic [CNT_W-1:0] sat_inc_fault(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating increment of the shift counter at CFG_W.
    function automatic logic [CNT_BITS-1:0] sat_inc_shift(input logic [CNT_BITS-1:0] v);
        return (v == SHIFT_FULL) ? v : v + 1'b1;
    endfunction

    assign state     = vote3(s0, s1, s2);
    assign addr      = {state, in_vec};
    assign cfg_full  = (cfg_st == CFG_READY);
    assign commit_go = cfg_commit && cfg_full;
    assign mismatch  = (s0 != s1) || (s1 != s2);

    // Table lookup: each function contributes the bit at the current address.
    for (genvar j = 0; j < N_FN; j++) begin : g_lut
        assign lut_bits[j] = active[j][addr];
    end

    assign lut_ns  = lut_bits[N_ST-1:0];
    assign lut_out = lut_bits[N_FN-1:N_ST];

    // Fault injection: only the selected copy sees the XOR mask.
    always_comb begin
        inj0 = inj_en && (inj_sel == 2'd0);
        inj1 = inj_en && (inj_sel == 2'd1);
        inj2 = inj_en && (inj_sel == 2'd2);
        n0   = lut_ns ^ (inj0 ? inj_mask : '0);
        n1   = lut_ns ^ (inj1 ? inj_mask : '0);
        n2   = lut_ns ^ (inj2 ? inj_mask : '0);
    end

    // Loader next-state: a commit empties it, each shift advances it.
    always_comb begin
        cfg_nx       = cfg_st;
        shift_cnt_nx = sat_inc_shift(shift_cnt);
        if (commit_go) begin
            cfg_nx = CFG_EMPTY;
        end else if (cfg_shift) begin
            cfg_nx = (shift_cnt_nx == SHIFT_FULL) ? CFG_READY : CFG_FILLING;
        end
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_st <= CFG_EMPTY;
        end else begin
            cfg_st <= cfg_nx;
        end
    end

    // Shadow buffer, shift count and active table; commit takes priority over
    // shift so a bit arriving on the commit edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            active    <= '0;
            shift_cnt <= '0;
        end else if (commit_go) begin
            active    <= shadow;
            shift_cnt <= '0;
        end else if (cfg_shift) begin
            shadow    <= {cfg_sdi, shadow[CFG_W-1:1]};
            shift_cnt <= shift_cnt_nx;
        end
    end

    // Triplicated state and registered outputs. Every copy reloads from the
    // voted lookup, which scrubs any single corrupted copy each cycle.
    always_ff @(posedge clk) begin
        if (rst || commit_go) begin
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
            out_vec <= '0;
        end else begin
            s0      <= n0;
            s1      <= n1;
            s2      <= n2;
            out_vec <= lut_out;
        end
    end

    // Disagreement flag and saturating counter for the health monitor.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_flag <= 1'b0;
            fault_cnt  <= '0;
        end else begin
            fault_flag <= mismatch;
            if (mismatch) begin
                fault_cnt <= sat_inc_fault(fault_cnt);
            end
        end
    end

endmodule

// File: tb/tb_sat_fsm_lut_tmr.sv
// Bench for sat_fsm_lut_tmr: two instances share all inputs, one with the
// default 8-bit fault counter and one with a 2-bit counter for saturation.
module tb_sat_fsm_lut_tmr;

    localparam int CFG_W = 512;
    localparam int DEPTH = 128;

    typedef logic [21:0] obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] in_vec = '0;
    logic       cfg_sdi = 1'b0;
    logic       cfg_shift = 1'b0;
    logic       cfg_commit = 1'b0;
    logic       inj_en = 1'b0;
    logic [1:0] inj_sel = 2'd3;
    logic [1:0] inj_mask = '0;

    logic [1:0] state, out_vec, state2, out_vec2;
    logic       cfg_full, cfg_full2, fault_flag, fault_flag2;
    logic [7:0] fault_cnt;
    logic [1:0] fault_cnt2;

    obs_t sb[$];
    obs_t got, e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [7:0] exp_cnt8 = '0;
    logic [1:0] exp_cnt2 = '0;
    logic [CFG_W-1:0] up_cfg, down_cfg;

    always #5 clk = ~clk;

    sat_fsm_lut_tmr #(.N_IN(5), .N_ST(2), .N_OUT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_vec(in_vec), .cfg_sdi(cfg_sdi),
        .cfg_shift(cfg_shift), .cfg_commit(cfg_commit), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .state(state),
        .out_vec(out_vec), .cfg_full(cfg_full), .fault_flag(fault_flag),
        .fault_cnt(fault_cnt)
    );

    sat_fsm_lut_tmr #(.N_IN(5), .N_ST(2), .N_OUT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_vec(in_vec), .cfg_sdi(cfg_sdi),
        .cfg_shift(cfg_shift), .cfg_commit(cfg_commit), .inj_en(inj_en),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .state(state2),
        .out_vec(out_vec2), .cfg_full(cfg_full2), .fault_flag(fault_flag2),
        .fault_cnt(fault_cnt2)
    );

    // Table builder: C1 (in_vec[3]) steps the state up (or down), out = state (or ~state).
    function automatic logic [CFG_W-1:0] make_cfg(input bit down);
        logic [CFG_W-1:0] c;
        logic [6:0] av;
        logic [1:0] st, nx, ov;
        c = '0;
        for (int a = 0; a < DEPTH; a++) begin
            av = a[6:0];
            st = av[6:5];
            if (av[3]) nx = down ? st - 2'd1 : st + 2'd1;
            else       nx = st;
            ov = down ? ~st : st;
            c[a]           = nx[0];
            c[DEPTH + a]   = nx[1];
            c[2*DEPTH + a] = ov[0];
            c[3*DEPTH + a] = ov[1];
        end
        return c;
    endfunction

    function automatic obs_t observe();
        return {state, out_vec, cfg_full, fault_flag, fault_cnt,
                state2, out_vec2, cfg_full2, fault_flag2, fault_cnt2};
    endfunction

    function automatic obs_t expect_of(input logic [1:0] st, input logic [1:0] ov,
                                       input logic full, input logic flag);
        return {st, ov, full, flag, exp_cnt8, st, ov, full, flag, exp_cnt2};
    endfunction

    task automatic drive(input logic [4:0] iv, input logic sh, input logic sdi,
                         input logic cm, input logic ie, input logic [1:0] sel,
                         input logic [1:0] msk, input logic r);
        @(negedge clk);
        in_vec = iv; cfg_shift = sh; cfg_sdi = sdi; cfg_commit = cm;
        inj_en = ie; inj_sel = sel; inj_mask = msk; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_cfg(input logic [CFG_W-1:0] cfg, input int from, input int num,
                             input logic [4:0] iv);
        for (int i = from; i < from + num; i++) drive(iv, 1'b1, cfg[i], 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        logic [4:0] pats [4];
        pats = '{5'h00, 5'h1F, 5'h08, 5'h15};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
            drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL reset_state got=%h exp=%h", got, e); else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
            drive(pats[i], 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL zero_cfg_hold got=%h exp=%h", got, e); else n_pass++;
        end
    endtask

    task automatic test_counter();
        logic [1:0] st_seq [5];
        logic [1:0] ov_seq [5];
        logic [4:0] iv_seq [5];
        st_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ov_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        iv_seq = '{5'h08, 5'h0F, 5'h1A, 5'h09, 5'h18};
        shift_cfg(up_cfg, 0, CFG_W, 5'h00);
        sb.push_back(expect_of(2'd0, 2'd0, 1'b1, 1'b0));
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL counter_full got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        drive(5'h08, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL counter_commit got=%h exp=%h", got, e); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(expect_of(st_seq[i], ov_seq[i], 1'b0, 1'b0));
            drive(iv_seq[i], 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL counter_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(expect_of(2'd1, 2'd1, 1'b0, 1'b0));
            drive(5'h17, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL counter_hold got=%h exp=%h", got, e); else n_pass++;
        end
    endtask

    task automatic test_single_upset();
        sb.push_back(expect_of(2'd2, 2'd1, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL upset_pre got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd3, 2'd2, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'b11, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL upset_inject got=%h exp=%h", got, e); else n_pass++;
        exp_cnt8 = 8'd1; exp_cnt2 = 2'd1;
        sb.push_back(expect_of(2'd3, 2'd3, 1'b0, 1'b1));
        drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL upset_flag got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd3, 2'd3, 1'b0, 1'b0));
        drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL upset_scrubbed got=%h exp=%h", got, e); else n_pass++;
    endtask

    task automatic test_saturation();
        logic flag;
        for (int i = 0; i < 7; i++) begin
            flag = (i >= 1) && (i <= 5);
            if (flag) begin
                exp_cnt8 = exp_cnt8 + 8'd1;
                if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
            end
            sb.push_back(expect_of(2'd3, 2'd3, 1'b0, flag));
            drive(5'h00, 1'b0, 1'b0, 1'b0, (i < 5), 2'd0, 2'b01, 1'b0);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL sat_inject%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back(expect_of(2'd3, 2'd3, 1'b0, 1'b0));
            drive(5'h04, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'b11, 1'b0);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL sel3_no_fault got=%h exp=%h", got, e); else n_pass++;
        end
    endtask

    task automatic test_partial_load();
        shift_cfg(down_cfg, 0, 300, 5'h00);
        sb.push_back(expect_of(2'd3, 2'd3, 1'b0, 1'b0));
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL partial_not_full got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd3, 2'd3, 1'b0, 1'b0));
        drive(5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL partial_commit_ignored got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd0, 2'd3, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL partial_old_cfg got=%h exp=%h", got, e); else n_pass++;
        shift_cfg(down_cfg, 300, 212, 5'h00);
        sb.push_back(expect_of(2'd0, 2'd0, 1'b1, 1'b0));
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL partial_full got=%h exp=%h", got, e); else n_pass++;
        // Commit with a simultaneous injection: commit wins.
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'b11, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL commit_vs_inject got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd3, 2'd3, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL new_cfg_step1 got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd2, 2'd0, 1'b0, 1'b0));
        drive(5'h0B, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL new_cfg_step2 got=%h exp=%h", got, e); else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        shift_cfg(up_cfg, 0, 100, 5'h00);
        exp_cnt8 = '0; exp_cnt2 = '0;
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        drive(5'h08, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'b11, 1'b1);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL midshift_reset got=%h exp=%h", got, e); else n_pass++;
        shift_cfg(up_cfg, 100, 412, 5'h00);
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL midshift_not_full got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL midshift_commit_ignored got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        drive(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL midshift_zero_cfg got=%h exp=%h", got, e); else n_pass++;
    endtask

    task automatic test_overshift();
        // Count is already 412; these 512 shifts saturate it and the shadow
        // ends up holding exactly the last 512 bits.
        shift_cfg(up_cfg, 0, CFG_W, 5'h00);
        sb.push_back(expect_of(2'd0, 2'd0, 1'b1, 1'b0));
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL overshift_full got=%h exp=%h", got, e); else n_pass++;
        sb.push_back(expect_of(2'd0, 2'd0, 1'b0, 1'b0));
        drive(5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        got = observe(); e = sb.pop_front(); n_checks++;
        if (got !== e) $display("FAIL overshift_commit got=%h exp=%h", got, e); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(expect_of(2'(i + 1), 2'(i), 1'b0, 1'b0));
            drive(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
            got = observe(); e = sb.pop_front(); n_checks++;
            if (got !== e) $display("FAIL overshift_step%0d got=%h exp=%h", i, got, e); else n_pass++;
        end
    endtask

    initial begin
        up_cfg   = make_cfg(1'b0);
        down_cfg = make_cfg(1'b1);
        test_reset();
        test_counter();
        test_single_upset();
        test_saturation();
        test_partial_load();
        test_reset_mid_shift();
        test_overshift();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sat_fsm_lut_tmr.md
# sat_fsm_lut_tmr

Clocked, parametrised successor to the combinational satellite-mode FSM fabric: next-state and output logic are runtime-reconfigurable lookup tables, loaded serially into a shadow buffer and committed atomically. State is held in a triple-modular-redundant register with majority voting and per-cycle scrubbing. Disagreements are flagged and counted for the health monitor. It sits between the sensor/command inputs (I1..I3, C1, C2 packed into `in_vec`) and the mode outputs (N1, N2 packed into `out_vec`).

## Interface
- N_IN, 5, number of input bits (I/C lines)
- N_ST, 2, state bits (up to 4 modes)
- N_OUT, 2, output bits
- CNT_W, 8, fault counter width
- Derived: A_W = N_ST+N_IN; DEPTH = 2^A_W; CFG_W = (N_ST+N_OUT)*DEPTH

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_vec  in  N_IN  FSM inputs, sampled every edge
- cfg_sdi  in  1  serial configuration data
- cfg_shift  in  1  shift cfg_sdi into shadow buffer this cycle
- cfg_commit  in  1  copy shadow to active config (only when cfg_full)
- inj_en  in  1  fault-injection strobe
- inj_sel  in  2  TMR copy to corrupt (0..2; 3 = none)
- inj_mask  in  N_ST  XOR mask applied to selected copy
- state  out  N_ST  voted state
- out_vec  out  N_OUT  registered FSM outputs
- cfg_full  out  1  CFG_W bits shifted since last commit/reset
- fault_flag  out  1  copies disagreed in previous cycle
- fault_cnt  out  CNT_W  saturating disagreement count

## Operation
- Config layout: function j (0..N_ST-1 = next-state bit j; N_ST..N_ST+N_OUT-1 = output bit j-N_ST) occupies active[j*DEPTH +: DEPTH]; addressed by A = {state, in_vec}.
- Shift: on cfg_shift, shadow <= {cfg_sdi, shadow[CFG_W-1:1]}. The first bit shifted lands at bit 0 after CFG_W shifts. Shift counter increments, saturating at CFG_W; cfg_full = (count == CFG_W). Shifts beyond CFG_W keep shifting, and the count stays saturated.
- Commit: on cfg_commit while cfg_full:
  - active <= shadow; count <= 0.
  - All three state copies <= 0 and out_vec <= 0 on that edge.
  - Shift is ignored in a commit cycle.
- cfg_commit while !cfg_full is ignored.
- Normal step, every edge not in reset or commit:
  - next = LUT_ns(A); each copy s0/s1/s2 <= next.
  - out_vec <= LUT_out(A).
  - The voted state is written back to all copies, so a single upset is scrubbed in one cycle.
- Vote: state = bitwise majority(s0, s1, s2), combinational from the registers.
- Injection: when inj_en and inj_sel<3, copy inj_sel loads next ^ inj_mask; the other copies load next.
- Fault detect: mismatch = (s0!=s1)|(s1!=s2). fault_flag <= mismatch. fault_cnt increments when mismatch, saturating at 2^CNT_W-1.
- Reset: shadow, active, count, s0..s2, out_vec, fault_flag and fault_cnt all go to 0. Zero config holds state 0 with outputs 0.
- Reset mid-shift discards the partial load. Reset has priority over commit, shift and injection.

## Timing
- Single-edge latency: in_vec sampled at edge k gives state and out_vec valid after edge k (registered Mealy).
- Injection at edge k: the corrupted copy is visible after k; the voted state is unchanged. fault_flag=1 and fault_cnt+1 after edge k+1; the copy is scrubbed at k+1.
- cfg_full rises after the CFG_W-th shift edge. The committed config is used from the first edge after the commit edge.
- Simultaneous commit and inj_en: commit wins and all copies are zeroed.

## Test plan
- Reset: assert rst 2 cycles -> state=0, out_vec=0, cfg_full=0, fault_cnt=0; with zero config, any in_vec keeps state=0.
- Counter config: load a config where next = state+1 if in_vec[3] (C1)=1 else state, and out = state; shift 512 bits then commit. Hold C1=1 for 5 cycles -> state 1,2,3,0,1. Set C1=0 -> state holds.
- Partial load: 300 shifts then commit -> ignored, active config unchanged, cfg_full=0. Complete the remaining 212 shifts, then commit -> takes effect.
- Single upset: in state 2, inj_en with inj_sel=1 and mask=2'b11 -> state still follows the config. fault_flag=1 for exactly one cycle; fault_cnt increments by 1.
- Saturation: set CNT_W=2 and inject 5 consecutive cycles -> fault_cnt stops at 3. inj_sel=3 -> no mismatch.
- Reset mid-shift: rst after 100 shifts -> count=0; a commit after 412 more shifts is ignored (cfg_full=0).
